// File: rtl/vga_layer_compositor.sv
// Two-stage VGA layer compositor with frame-synchronous layer enables.
// Also provides frame counting and a free-running movement divider.
module vga_layer_compositor #(
  parameter int                    N_LAYERS     = 4,
  parameter logic [11:0]           KEY_COLOR    = 12'hFFF,
  parameter logic [11:0]           BG_COLOR     = 12'hFFF,
  parameter logic [N_LAYERS-1:0]   EN_INIT      = '1,
  parameter int                    MOVE_DIV_BIT = 19
) (
  input  logic                     ClkPort,
  input  logic                     Reset,
  input  logic                     hSync_in,
  input  logic                     vSync_in,
  input  logic                     bright_in,
  input  logic [9:0]               hc_in,
  input  logic [9:0]               vc_in,
  input  logic [12*N_LAYERS-1:0]   layer_rgb,
  input  logic [N_LAYERS-1:0]      layer_en_req,
  output logic                     hSync,
  output logic                     vSync,
  output logic                     bright,
  output logic [9:0]               hc,
  output logic [9:0]               vc,
  output logic [3:0]               vgaR,
  output logic [3:0]               vgaG,
  output logic [3:0]               vgaB,
  output logic [2:0]               hit_layer,
  output logic                     hit,
  output logic [N_LAYERS-1:0]      layer_en_active,
  output logic [15:0]              frame_count,
  output logic                     move_clk,
  output logic                     move_tick
);

  logic                   s1_hs;
  logic                   s1_vs;
  logic                   s1_br;
  logic [9:0]             s1_hc;
  logic [9:0]             s1_vc;
  logic [12*N_LAYERS-1:0] s1_rgb;

  logic                   win_found;
  logic [2:0]             win_idx;
  logic [11:0]            win_rgb;
  logic                   frame_start;

  logic [MOVE_DIV_BIT:0]  div_cnt;

  // Stage 1: capture raw timing and layer colours; syncs idle high.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      s1_hs  <= 1'b1;
      s1_vs  <= 1'b1;
      s1_br  <= 1'b0;
      s1_hc  <= '0;
      s1_vc  <= '0;
      s1_rgb <= '0;
    end else begin
      s1_hs  <= hSync_in;
      s1_vs  <= vSync_in;
      s1_br  <= bright_in;
      s1_hc  <= hc_in;
      s1_vc  <= vc_in;
      s1_rgb <= layer_rgb;
    end
  end

  // Priority select: the highest enabled, non-transparent layer wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    win_rgb   = BG_COLOR;
    for (int i = 0; i < N_LAYERS; i++) begin
      if (layer_en_active[i] && (s1_rgb[12*i +: 12] != KEY_COLOR)) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_rgb   = s1_rgb[12*i +: 12];
      end
    end
  end

  // Stage 2: aligned timing plus composited colour, blanked outside video.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      hSync              <= 1'b1;
      vSync              <= 1'b1;
      bright             <= 1'b0;
      hc                 <= '0;
      vc                 <= '0;
      {vgaR, vgaG, vgaB} <= '0;
      hit                <= 1'b0;
      hit_layer          <= '0;
    end else begin
      hSync              <= s1_hs;
      vSync              <= s1_vs;
      bright             <= s1_br;
      hc                 <= s1_hc;
      vc                 <= s1_vc;
      {vgaR, vgaG, vgaB} <= s1_br ? win_rgb : 12'h000;
      hit                <= win_found;
      hit_layer          <= win_idx;
    end
  end

  // vSync holds the previous registered vSync_in, so this is its falling edge.
  assign frame_start = vSync & ~s1_vs;

  // Frame-synchronous enable mask and frame counter.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      layer_en_active <= EN_INIT;
      frame_count     <= '0;
    end else if (frame_start) begin
      layer_en_active <= layer_en_req;
      frame_count     <= frame_count + 16'd1;
    end
  end

  // Free-running divider; tick follows the all-ones count by one cycle.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      div_cnt   <= '0;
      move_tick <= 1'b0;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
      move_tick <= &div_cnt;
    end
  end

  assign move_clk = div_cnt[MOVE_DIV_BIT];

endmodule

// File: doc/vga_layer_compositor.md
VGA_LAYER_COMPOSITOR -- requirements
Module: vga_layer_compositor

Interface
REQ-001 Parameter N_LAYERS, default 4: number of RGB layers (1..8); layer 0 has lowest priority, layer N_LAYERS-1 highest.
REQ-002 Parameter KEY_COLOR, default 12'hFFF: transparent colour key; a layer pixel equal to it is treated as "not drawn".
REQ-003 Parameter BG_COLOR, default 12'hFFF: colour shown where no enabled layer draws.
REQ-004 Parameter EN_INIT, default all ones (N_LAYERS bits): reset value of the active layer-enable mask.
REQ-005 Parameter MOVE_DIV_BIT, default 19: divider bit that sets the movement tick rate.
REQ-006 ClkPort  in  1  system clock; all state is updated on its rising edge.
REQ-007 Reset  in  1  asynchronous, active-high reset.
REQ-008 hSync_in, vSync_in, bright_in  in  1 each  raw timing from the display controller; syncs are active-low.
REQ-009 hc_in, vc_in  in  10 each  raw pixel counters.
REQ-010 layer_rgb  in  12*N_LAYERS  packed layer colours; layer i occupies bits [12i+11:12i], R in the top nibble.
REQ-011 layer_en_req  in  N_LAYERS  requested layer-enable mask, sampled only at frame start.
REQ-012 hSync, vSync, bright  out  1 each  timing delayed to align with the colour outputs.
REQ-013 hc, vc  out  10 each  counters delayed to align with the colour outputs.
REQ-014 vgaR, vgaG, vgaB  out  4 each  composited pixel colour.
REQ-015 hit_layer  out  3  index of the winning layer, aligned with the colour outputs; valid only when hit is high.
REQ-016 hit  out  1  high when some enabled layer drew the current pixel.
REQ-017 layer_en_active  out  N_LAYERS  mask currently used for compositing.
REQ-018 frame_count  out  16  count of frame starts since reset.
REQ-019 move_clk  out  1  divider bit MOVE_DIV_BIT, a square wave for the object controllers.
REQ-020 move_tick  out  1  single-cycle pulse, once per divider period.

Function
REQ-021 The block is a two-stage pipeline that advances every ClkPort cycle: stage 1 registers all *_in signals and layer_rgb; stage 2 registers the composite result.
REQ-022 Total latency from inputs to outputs is exactly 2 cycles for hSync, vSync, bright, hc, vc, colour, hit and hit_layer.
REQ-023 Stage-2 selection: winner = highest index i with layer_en_active[i]=1 and stage-1 layer i colour != KEY_COLOR.
REQ-024 If a winner exists: colour = winner's colour, hit=1, hit_layer=i; otherwise colour = BG_COLOR, hit=0, hit_layer=0.
REQ-025 When stage-1 bright=0, vgaR/G/B shall output 0 regardless of layers; hit and hit_layer are still computed.
REQ-026 Frame start is the cycle in which the registered vSync_in is 1 in the previous cycle and 0 in the current cycle (a falling edge).
REQ-027 On frame start, layer_en_active <= layer_en_req and frame_count <= frame_count+1, wrapping 16'hFFFF -> 0.
REQ-028 layer_en_active changes only on frame start; changes to layer_en_req at any other time have no effect.
REQ-029 Divider: a (MOVE_DIV_BIT+1)-bit free-running counter; move_clk = counter[MOVE_DIV_BIT].
REQ-030 move_tick = 1 in the cycle after the counter held all ones, giving period 2^(MOVE_DIV_BIT+1) cycles.
REQ-031 The enable mask used in stage 2 on a frame-start cycle is the pre-update mask; the new mask applies from the next cycle.
REQ-032 Bits above N_LAYERS-1 of hit_layer shall be 0; when N_LAYERS=1, hit_layer is always 0.

Reset
REQ-033 While Reset=1: all pipeline registers are 0, except hSync and vSync pipeline stages, which are 1 (idle).
REQ-034 While Reset=1: outputs are hSync=vSync=1, bright=0, colour=0, hit=0, hit_layer=0, frame_count=0, divider=0, move_tick=0, and layer_en_active=EN_INIT.
REQ-035 Reset asserted mid-frame aborts the pipeline immediately; after release, the first valid output appears 2 cycles later.
REQ-036 After release, the edge detector does not report a frame start on the first cycle.

Verification
REQ-037 N=4, en=1111, bright=1, layers {0:0F00, 1:FFF, 2:00F0, 3:FFF} -> 2 cycles later RGB=00F0, hit=1, hit_layer=2.
REQ-038 All layers = FFF, bright=1 -> RGB=FFF (BG_COLOR), hit=0; same stimulus with bright=0 -> RGB=000.
REQ-039 Change layer_en_req to 0001 mid-frame -> layer_en_active unchanged until the next vSync falling edge, then = 0001 and frame_count increments by 1.
REQ-040 Preload frame_count=FFFF via 65535 frame starts (or force), then apply one more frame start -> frame_count=0000.
REQ-041 MOVE_DIV_BIT=3 -> move_tick pulses every 16 cycles, and move_clk toggles every 8 cycles.
REQ-042 Assert Reset during active video -> outputs at reset values immediately; layer_en_active = EN_INIT; hc/vc track hc_in/vc_in with 2-cycle lag after release.
